// File: rtl/gearbox_param.sv
`default_nettype none
// ============================================================================
//  Module   : gearbox_param
//  Purpose  : Parametrised LSB-first width converter (IN_W -> OUT_W) through
//             a BUF_W-bit bit-level buffer, with zero-padding flush of the
//             trailing partial word and a fill-level status output.
//  Revision : 1.0  initial release
// ============================================================================
module gearbox_param #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 20,
   parameter int BUF_W = 64,
   parameter int LVL_W = $clog2(BUF_W + 1)
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             shift_in,
   input  logic [IN_W-1:0]  data_in,
   output logic             full,
   input  logic             flush,
   output logic             flushing,
   output logic             valid_out,
   input  logic             shift_out,
   output logic [OUT_W-1:0] data_out,
   output logic [LVL_W-1:0] fill_level
);

   // The buffer must always hold one partial output word plus one new input.
   generate
      if (BUF_W < IN_W + OUT_W) begin : g_buf_too_small
         $error("gearbox_param: BUF_W must be >= IN_W + OUT_W");
      end
   endgenerate

   localparam logic [LVL_W-1:0] IN_L  = LVL_W'(IN_W);
   localparam logic [LVL_W-1:0] OUT_L = LVL_W'(OUT_W);
   localparam logic [LVL_W-1:0] MAX_L = LVL_W'(BUF_W - IN_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LAST  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BUF_W-1:0]   buf_q,   buf_d;
   logic [LVL_W-1:0]   fill_q,  fill_d;

   logic               accept;
   logic               pop;
   logic [BUF_W-1:0]   base_buf;
   logic [LVL_W-1:0]   base_fill;
   logic [BUF_W-1:0]   ext_in;

   // Status flags come only from registered state, never from inputs.
   assign flushing   = (state_q != ST_IDLE);
   assign valid_out  = (fill_q >= OUT_L);
   assign full       = (fill_q > MAX_L) || flushing;
   assign fill_level = fill_q;
   assign data_out   = buf_q[OUT_W-1:0];

   // Both handshakes are decided from pre-edge flags.
   assign accept = shift_in && !full;
   assign pop    = shift_out && valid_out;
   assign ext_in = {{(BUF_W-IN_W){1'b0}}, data_in};

   // Register state, buffer and fill counter; reset wins over everything.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
      end
   end

   // Next-state: pop shifts first, then the new word lands at the post-pop fill.
   always_comb begin
      state_d   = state_q;
      base_buf  = pop ? (buf_q >> OUT_W) : buf_q;
      base_fill = pop ? (fill_q - OUT_L) : fill_q;
      buf_d     = base_buf;
      fill_d    = base_fill;

      if (accept) begin
         buf_d  = base_buf | (ext_in << base_fill);
         fill_d = base_fill + IN_L;
      end

      case (state_q)
         ST_IDLE: begin
            if (flush && (fill_q != '0)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && (base_fill == '0)) begin
               state_d = ST_IDLE;
            end else if (fill_q == '0) begin
               state_d = ST_IDLE;
            end else if (fill_q < OUT_L) begin
               // Upper buffer bits are already zero, so padding is just a
               // fill bump to a full word.
               fill_d  = OUT_L;
               state_d = ST_LAST;
            end
         end
         ST_LAST: begin
            if (pop && (base_fill == '0)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_gearbox_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gearbox_param
//  Purpose  : Directed self-checking bench for gearbox_param (16 -> 20, 64).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gearbox_param;

   localparam int IN_W  = 16;
   localparam int OUT_W = 20;
   localparam int BUF_W = 64;
   localparam int LVL_W = $clog2(BUF_W + 1);

   logic             clk;
   logic             res_n;
   logic             shift_in;
   logic [IN_W-1:0]  data_in;
   logic             full;
   logic             flush;
   logic             flushing;
   logic             valid_out;
   logic             shift_out;
   logic [OUT_W-1:0] data_out;
   logic [LVL_W-1:0] fill_level;

   int n_checks;
   int n_fail;

   gearbox_param #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .BUF_W (BUF_W)
   ) u_dut (
      .clk        (clk),
      .res_n      (res_n),
      .shift_in   (shift_in),
      .data_in    (data_in),
      .full       (full),
      .flush      (flush),
      .flushing   (flushing),
      .valid_out  (valid_out),
      .shift_out  (shift_out),
      .data_out   (data_out),
      .fill_level (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      res_n     = 1'b0;
      shift_in  = 1'b0;
      shift_out = 1'b0;
      flush     = 1'b0;
      data_in   = '0;
      step();
      res_n = 1'b1;
   endtask

   task automatic push(input logic [IN_W-1:0] w);
      shift_in = 1'b1;
      data_in  = w;
      step();
      shift_in = 1'b0;
   endtask

   // Fill must stay within the buffer on every cycle.
   always @(negedge clk) begin
      check_eq("fill_range", 64'(fill_level <= LVL_W'(BUF_W)), 64'd1);
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      res_n     = 1'b0;
      shift_in  = 1'b1;
      shift_out = 1'b0;
      flush     = 1'b0;
      data_in   = 16'hFFFF;

      // ---------------- Reset held with shift_in asserted ----------------
      step();
      step();
      check_eq("rst_full",  64'(full),       64'd0);
      check_eq("rst_valid", 64'(valid_out),  64'd0);
      check_eq("rst_data",  64'(data_out),   64'd0);
      check_eq("rst_fill",  64'(fill_level), 64'd0);
      check_eq("rst_flsh",  64'(flushing),   64'd0);
      res_n    = 1'b1;
      shift_in = 1'b0;

      // ---------------- Packing with continuous pop ----------------
      shift_out = 1'b1;
      shift_in  = 1'b1;
      data_in = 16'h1111; step();
      check_eq("pk_valid0", 64'(valid_out), 64'd0);
      data_in = 16'h2222; step();
      check_eq("pk_w0", 64'(data_out), 64'h21111);
      data_in = 16'h3333; step();
      check_eq("pk_w1", 64'(data_out), 64'h33222);
      data_in = 16'h4444; step();
      check_eq("pk_w2", 64'(data_out), 64'h44433);
      data_in = 16'h5555; step();
      check_eq("pk_w3", 64'(data_out), 64'h55554);
      check_eq("pk_vld3", 64'(valid_out), 64'd1);
      shift_in = 1'b0;
      step();
      check_eq("pk_fill_end",  64'(fill_level), 64'd0);
      check_eq("pk_valid_end", 64'(valid_out),  64'd0);
      shift_out = 1'b0;

      // ---------------- Full / backpressure ----------------
      do_reset();
      push(16'hA001);
      push(16'hA002);
      push(16'hA003);
      check_eq("bp_fill48", 64'(fill_level), 64'd48);
      check_eq("bp_nfull48", 64'(full), 64'd0);
      push(16'hA004);
      check_eq("bp_fill64", 64'(fill_level), 64'd64);
      check_eq("bp_full",   64'(full),       64'd1);
      push(16'hA005);
      check_eq("bp_ignored", 64'(fill_level), 64'd64);
      shift_in  = 1'b1;
      shift_out = 1'b1;
      data_in   = 16'hA006;
      check_eq("bp_head", 64'(data_out), 64'h2A001);
      step();
      shift_in  = 1'b0;
      shift_out = 1'b0;
      check_eq("bp_fill44", 64'(fill_level), 64'd44);
      check_eq("bp_nfull",  64'(full),       64'd0);
      check_eq("bp_next",   64'(data_out),   64'h03A00);

      // ---------------- Single-word flush ----------------
      do_reset();
      push(16'hABCD);
      check_eq("fl_fill16", 64'(fill_level), 64'd16);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("fl_flushing", 64'(flushing), 64'd1);
      check_eq("fl_full",     64'(full),     64'd1);
      step();
      check_eq("fl_valid", 64'(valid_out),  64'd1);
      check_eq("fl_data",  64'(data_out),   64'h0ABCD);
      check_eq("fl_fill",  64'(fill_level), 64'd20);
      shift_out = 1'b1;
      step();
      shift_out = 1'b0;
      check_eq("fl_done",  64'(flushing),   64'd0);
      check_eq("fl_fill0", 64'(fill_level), 64'd0);
      check_eq("fl_nfull", 64'(full),       64'd0);

      // ---------------- Flush with backlog ----------------
      do_reset();
      push(16'h1111);
      push(16'h2222);
      push(16'h3333);
      check_eq("bl_w0", 64'(data_out), 64'h21111);
      flush     = 1'b1;
      shift_out = 1'b1;
      step();
      flush = 1'b0;
      check_eq("bl_flushing", 64'(flushing), 64'd1);
      check_eq("bl_w1",       64'(data_out), 64'h33222);
      step();
      check_eq("bl_part_fill", 64'(fill_level), 64'd8);
      check_eq("bl_part_vld",  64'(valid_out),  64'd0);
      step();
      check_eq("bl_pad",     64'(data_out), 64'h00033);
      check_eq("bl_pad_vld", 64'(valid_out), 64'd1);
      check_eq("bl_pad_fl",  64'(flushing), 64'd1);
      step();
      shift_out = 1'b0;
      check_eq("bl_done",  64'(flushing),   64'd0);
      check_eq("bl_fill0", 64'(fill_level), 64'd0);

      // ---------------- Reset while in LAST ----------------
      do_reset();
      push(16'hBEEF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      check_eq("rl_in_last", 64'(valid_out), 64'd1);
      res_n     = 1'b0;
      shift_out = 1'b1;
      step();
      res_n     = 1'b1;
      shift_out = 1'b0;
      check_eq("rl_flush", 64'(flushing),   64'd0);
      check_eq("rl_full",  64'(full),       64'd0);
      check_eq("rl_valid", 64'(valid_out),  64'd0);
      check_eq("rl_data",  64'(data_out),   64'd0);
      check_eq("rl_fill",  64'(fill_level), 64'd0);
      // IDLE again: a normal word is accepted.
      push(16'h0042);
      check_eq("rl_accept", 64'(fill_level), 64'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
